// File: rtl/if16ba_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if16ba_fetch
//  Description : Instruction fetch stage of the 16-bit core. Owns the PC,
//                fetches words over an imem req/ack handshake and hands them
//                to decode over a valid/ready handshake. Redirects from
//                execute restart fetch at a new PC.
//                Optional macro IF16BA_HALT_EN: a delivered jump-to-self
//                parks the stage in HALT until rst or redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module if16ba_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] pc_out,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    inout  wire             dvdd,
    inout  wire             dgnd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FULL  = 3'd2,
        ST_DRAIN = 3'd3
`ifdef IF16BA_HALT_EN
        ,
        ST_HALT  = 3'd4
`endif
    } state_t;

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [PC_W-1:0] r_pc;

    // Supply pins carry no logic; they only exist for the physical netlist.
    wire w_unused_supply;
    assign w_unused_supply = dvdd ^ dgnd;

    // The memory address is the PC register itself, so it is stable while a
    // request is outstanding unless a redirect moves it.
    assign imem_addr = r_pc;

`ifdef IF16BA_HALT_EN
    // Word currently held for decode is a JMP whose target is its own address.
    logic w_self_jump;
    assign w_self_jump = (instr[15:12] == 4'hF) && (instr[PC_W-1:0] == pc_out);
`else
    assign halted = 1'b0;
`endif

    // Fetch FSM: PC, memory request and the decode-side output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            pc_out      <= RESET_PC;
`ifdef IF16BA_HALT_EN
            halted      <= 1'b0;
`endif
        end else if (redirect) begin
            // Redirect wins over everything; any held word is dropped.
            r_pc        <= redirect_pc;
            instr_valid <= 1'b0;
`ifdef IF16BA_HALT_EN
            halted      <= 1'b0;
`endif
            if (((r_state == ST_REQ) || (r_state == ST_DRAIN)) && !imem_ack) begin
                // A request cannot be withdrawn: wait out its ack, then refetch.
                r_state  <= ST_DRAIN;
                imem_req <= 1'b1;
            end else begin
                r_state  <= en ? ST_REQ : ST_IDLE;
                imem_req <= en;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state  <= ST_REQ;
                        imem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_out      <= r_pc;
                        instr_valid <= 1'b1;
                        r_pc        <= r_pc + c_pc_one;
                        r_state     <= ST_FULL;
                        imem_req    <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
`ifdef IF16BA_HALT_EN
                        if (w_self_jump) begin
                            r_state  <= ST_HALT;
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            r_state  <= en ? ST_REQ : ST_IDLE;
                            imem_req <= en;
                        end
`else
                        r_state  <= en ? ST_REQ : ST_IDLE;
                        imem_req <= en;
`endif
                    end
                end
                ST_DRAIN: begin
                    // Response belongs to the pre-redirect address: discard it.
                    if (imem_ack) begin
                        r_state  <= en ? ST_REQ : ST_IDLE;
                        imem_req <= en;
                    end
                end
`ifdef IF16BA_HALT_EN
                ST_HALT: begin
                    imem_req <= 1'b0;
                end
`endif
                default: begin
                    r_state  <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if16ba_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if16ba_fetch
//  Description : Directed, table-driven bench for if16ba_fetch. Instance u1
//                uses RESET_PC=0, instance u2 uses RESET_PC=8'hFE.
//                Honours IF16BA_HALT_EN for the jump-to-self sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if16ba_fetch;

    typedef struct {
        logic        en;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [7:0]  e_pc;
        logic        e_halt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;

    logic [7:0]  addr1, pc1, addr2, pc2;
    logic        req1, valid1, halt1, req2, valid2, halt2;
    logic [15:0] instr1, instr2;

    wire dvdd;
    wire dgnd;
    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if16ba_fetch #(.PC_W(8), .RESET_PC(8'h00)) u1 (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(addr1), .imem_req(req1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr1), .instr_valid(valid1), .instr_ready(instr_ready), .pc_out(pc1),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halt1),
        .dvdd(dvdd), .dgnd(dgnd)
    );

    if16ba_fetch #(.PC_W(8), .RESET_PC(8'hFE)) u2 (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(addr2), .imem_req(req2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr2), .instr_valid(valid2), .instr_ready(instr_ready), .pc_out(pc2),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halt2),
        .dvdd(dvdd), .dgnd(dgnd)
    );

    function automatic vec_t mk(input logic i_en, input logic i_ack, input logic [15:0] i_rd,
                                input logic i_rdy, input logic i_redir, input logic [7:0] i_rpc,
                                input logic x_req, input logic [7:0] x_addr, input logic x_valid,
                                input logic [15:0] x_instr, input logic [7:0] x_pc, input logic x_halt);
        vec_t v;
        v.en = i_en; v.ack = i_ack; v.rdata = i_rd; v.ready = i_rdy;
        v.redir = i_redir; v.rpc = i_rpc;
        v.e_req = x_req; v.e_addr = x_addr; v.e_valid = x_valid;
        v.e_instr = x_instr; v.e_pc = x_pc; v.e_halt = x_halt;
        return v;
    endfunction

    // Compare one DUT's outputs; instr/pc_out only matter while valid is expected.
    task automatic check(input string name, input int sel, input vec_t v);
        logic        a_req, a_valid, a_halt;
        logic [7:0]  a_addr, a_pc;
        logic [15:0] a_instr;
        bit          ok;
        if (sel == 1) begin
            a_req = req1; a_addr = addr1; a_valid = valid1; a_instr = instr1; a_pc = pc1; a_halt = halt1;
        end else begin
            a_req = req2; a_addr = addr2; a_valid = valid2; a_instr = instr2; a_pc = pc2; a_halt = halt2;
        end
        n_tests++;
        ok = (a_req === v.e_req) && (a_addr === v.e_addr) &&
             (a_valid === v.e_valid) && (a_halt === v.e_halt);
        if (v.e_valid)
            ok = ok && (a_instr === v.e_instr) && (a_pc === v.e_pc);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc_out=%h halted=%b ; want req=%b addr=%h valid=%b instr=%h pc_out=%h halted=%b",
                     name, a_req, a_addr, a_valid, a_instr, a_pc, a_halt,
                     v.e_req, v.e_addr, v.e_valid, v.e_instr, v.e_pc, v.e_halt);
        end
    endtask

    // Apply one vector's inputs, clock once, compare just after the edge.
    task automatic step(input string name, input int sel, input vec_t v);
        en = v.en; imem_ack = v.ack; imem_rdata = v.rdata;
        instr_ready = v.ready; redirect = v.redir; redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        check(name, sel, v);
    endtask

    task automatic check_reset(input string name, input int sel, input logic [7:0] rpc);
        logic        a_req, a_valid, a_halt;
        logic [7:0]  a_addr, a_pc;
        logic [15:0] a_instr;
        if (sel == 1) begin
            a_req = req1; a_addr = addr1; a_valid = valid1; a_instr = instr1; a_pc = pc1; a_halt = halt1;
        end else begin
            a_req = req2; a_addr = addr2; a_valid = valid2; a_instr = instr2; a_pc = pc2; a_halt = halt2;
        end
        n_tests++;
        if (!((a_req === 1'b0) && (a_addr === rpc) && (a_valid === 1'b0) &&
              (a_instr === 16'h0000) && (a_pc === rpc) && (a_halt === 1'b0))) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc_out=%h halted=%b ; want req=0 addr=%h valid=0 instr=0000 pc_out=%h halted=0",
                     name, a_req, a_addr, a_valid, a_instr, a_pc, a_halt, rpc, rpc);
        end
    endtask

    // Reset is asserted between clock edges so the checks see its async effect.
    task automatic do_reset(input string name);
        en = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        rst = 1'b1;
        #2;
        check_reset({name, "_u1"}, 1, 8'h00);
        check_reset({name, "_u2"}, 2, 8'hFE);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t wrap[$];

    initial begin
        // Main sequence on u1: en, ack, rdata, ready, redir, rpc | req, addr, valid, instr, pc_out, halted
        // Basic in-order fetch, one wait cycle before each ack.
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hA000, 0, 0, 8'h00,  0, 8'h01, 1, 16'hA000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h01, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h01, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hA001, 0, 0, 8'h00,  0, 8'h02, 1, 16'hA001, 8'h01, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h02, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h02, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h1234, 0, 0, 8'h00,  0, 8'h03, 1, 16'h1234, 8'h02, 0));
        // Decoder stall for 5 cycles: word held, no new request.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  0, 8'h03, 1, 16'h1234, 8'h02, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h03, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h03, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hB003, 0, 0, 8'h00,  0, 8'h04, 1, 16'hB003, 8'h03, 0));
        // Redirect in FULL together with ready: word dropped, refetch at 0x20.
        tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 8'h20,  1, 8'h20, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h20, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hC020, 0, 0, 8'h00,  0, 8'h21, 1, 16'hC020, 8'h20, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h21, 0, 16'h0000, 8'h00, 0));
        // Redirect while request pending: drain the stale ack, then fetch 0x40.
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 8'h40,  1, 8'h40, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h40, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hDEAD, 0, 0, 8'h00,  1, 8'h40, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h40, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h4040, 0, 0, 8'h00,  0, 8'h41, 1, 16'h4040, 8'h40, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h41, 0, 16'h0000, 8'h00, 0));
        // Redirect coinciding with ack: data discarded, straight to REQ at 0x60.
        tbl.push_back(mk(1, 1, 16'hBEEF, 0, 1, 8'h60,  1, 8'h60, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h6060, 0, 0, 8'h00,  0, 8'h61, 1, 16'h6060, 8'h60, 0));
        // en dropped mid-request: word still delivered, then IDLE.
        tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h61, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h61, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'h6161, 0, 0, 8'h00,  0, 8'h62, 1, 16'h6161, 8'h61, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h62, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,  0, 8'h62, 0, 16'h0000, 8'h00, 0));
        // Redirect in IDLE with en=0 only moves the PC.
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h10,  0, 8'h10, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h10, 0, 16'h0000, 8'h00, 0));
        // Two redirects while draining: newest target wins.
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 8'h30,  1, 8'h30, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 8'h31,  1, 8'h31, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'hDEAD, 0, 0, 8'h00,  1, 8'h31, 0, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h3131, 0, 0, 8'h00,  0, 8'h32, 1, 16'h3131, 8'h31, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h32, 0, 16'h0000, 8'h00, 0));

        // PC wrap on u2 (RESET_PC=FE), then en dropped mid-request.
        wrap.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'hFE, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(1, 1, 16'h00FE, 0, 0, 8'h00,  0, 8'hFF, 1, 16'h00FE, 8'hFE, 0));
        wrap.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'hFF, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(1, 1, 16'h00FF, 0, 0, 8'h00,  0, 8'h00, 1, 16'h00FF, 8'hFF, 0));
        wrap.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(1, 1, 16'h0100, 0, 0, 8'h00,  0, 8'h01, 1, 16'h0100, 8'h00, 0));
        wrap.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h01, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h01, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(0, 1, 16'h0101, 0, 0, 8'h00,  0, 8'h02, 1, 16'h0101, 8'h01, 0));
        wrap.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h02, 0, 16'h0000, 8'h00, 0));
        wrap.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,  0, 8'h02, 0, 16'h0000, 8'h00, 0));

        do_reset("reset0");
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("main_v%0d", i), 1, tbl[i]);

        do_reset("reset1");
        for (int i = 0; i < wrap.size(); i++)
            step($sformatf("wrap_v%0d", i), 2, wrap[i]);

        // Jump-to-self at address 5.
        do_reset("reset2");
        step("self_redir", 1, mk(0, 0, 16'h0000, 0, 1, 8'h05,  0, 8'h05, 0, 16'h0000, 8'h00, 0));
        step("self_req",   1, mk(1, 0, 16'h0000, 0, 0, 8'h00,  1, 8'h05, 0, 16'h0000, 8'h00, 0));
        step("self_full",  1, mk(1, 1, 16'hF005, 0, 0, 8'h00,  0, 8'h06, 1, 16'hF005, 8'h05, 0));
`ifdef IF16BA_HALT_EN
        step("halt_enter", 1, mk(1, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h06, 0, 16'h0000, 8'h00, 1));
        step("halt_hold0", 1, mk(1, 0, 16'h0000, 1, 0, 8'h00,  0, 8'h06, 0, 16'h0000, 8'h00, 1));
        step("halt_hold1", 1, mk(1, 1, 16'h1111, 1, 0, 8'h00,  0, 8'h06, 0, 16'h0000, 8'h00, 1));
        step("halt_exit",  1, mk(1, 0, 16'h0000, 0, 1, 8'h10,  1, 8'h10, 0, 16'h0000, 8'h00, 0));
        step("halt_fetch", 1, mk(1, 1, 16'h1010, 0, 0, 8'h00,  0, 8'h11, 1, 16'h1010, 8'h10, 0));
`else
        step("nohalt_go",  1, mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h06, 0, 16'h0000, 8'h00, 0));
        step("nohalt_jmp", 1, mk(1, 0, 16'h0000, 0, 1, 8'h05,  1, 8'h05, 0, 16'h0000, 8'h00, 0));
        step("nohalt_drn", 1, mk(1, 1, 16'hDEAD, 0, 0, 8'h00,  1, 8'h05, 0, 16'h0000, 8'h00, 0));
        step("nohalt_re",  1, mk(1, 1, 16'hF005, 0, 0, 8'h00,  0, 8'h06, 1, 16'hF005, 8'h05, 0));
        step("nohalt_nx",  1, mk(1, 0, 16'h0000, 1, 0, 8'h00,  1, 8'h06, 0, 16'h0000, 8'h00, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
